// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with programmable coefficients, shift and
// saturation; full-size centred output with zero or replicate borders.
module conv3x3_stream #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_WIDTH     = 512,
  parameter int IMAGE_HEIGHT    = 512,
  parameter int PIXEL_WIDTH     = 8,
  parameter int COEF_WIDTH      = 4
) (
  input  logic                                   clk,
  input  logic                                   areset,
  input  logic [9*COEF_WIDTH-1:0]                coef,
  input  logic [4:0]                             shift,
  input  logic                                   border_mode,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [PIXELS_PER_BEAT*PIXEL_WIDTH-1:0] in_frame,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [PIXELS_PER_BEAT*PIXEL_WIDTH-1:0] out_frame,
  output logic                                   frame_done
);

  localparam int PPB  = PIXELS_PER_BEAT;
  localparam int PW   = PIXEL_WIDTH;
  localparam int CW   = COEF_WIDTH;
  localparam int BW   = PPB * PW;
  localparam int AW   = PW + CW + 4;
  localparam int COLS = IMAGE_WIDTH / PPB;
  localparam int CCW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [CCW-1:0] LAST_COL = CCW'(COLS - 1);
  localparam logic [RW-1:0]  LAST_ROW = RW'(IMAGE_HEIGHT - 1);
  localparam logic [AW-1:0]  PMAX     = AW'((1 << PW) - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t           state;
  logic [CCW-1:0]   ccol;
  logic [RW-1:0]    crow;
  logic             wsel;
  logic             bubble;
  logic             bub_out;
  logic             last_bub;
  logic             done_wait;
  logic             live;
  logic [9*CW-1:0]  cfg_coef;
  logic [4:0]       cfg_shift;
  logic             cfg_mode;

  logic [BW-1:0]    lb [2][COLS];
  logic [BW-1:0]    win1 [3];
  logic [BW-1:0]    win2 [3];
  logic [BW-1:0]    nw [3];
  logic [BW-1:0]    mid_rd;
  logic [BW-1:0]    top_rd;
  logic [BW-1:0]    result;
  logic [PW-1:0]    ext [3][PPB+2];
  logic [AW-1:0]    sum;
  logic [AW-1:0]    sh;

  logic adv, acc, fstep, bstep, step;
  logic last_col, emit, left_edge;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = live & (state != FLUSH) & ~bubble & adv;
  assign acc      = in_valid & in_ready;
  assign fstep    = (state == FLUSH) & ~bubble & ~done_wait & adv;
  assign bstep    = bubble & adv;
  assign step     = acc | fstep;
  assign last_col = (ccol == LAST_COL);
  assign frame_done = done_wait & out_valid & out_ready;

  assign emit = (acc & (state == RUN) & (ccol != '0))
              | (fstep & (ccol != '0))
              | (bstep & bub_out);
  assign left_edge = bstep ? (COLS == 1) : (ccol == CCW'(1));

  // Writes land in the buffer holding row r-1; mid row lives in the other.
  assign mid_rd = lb[~wsel][ccol];
  assign top_rd = lb[wsel][ccol];

  always_comb begin
    nw[0] = top_rd;
    nw[1] = mid_rd;
    nw[2] = in_frame;
    if (state == RUN && crow == RW'(1))
      nw[0] = cfg_mode ? mid_rd : '0;
    if (state == FLUSH)
      nw[2] = cfg_mode ? mid_rd : '0;
  end

  always_comb begin
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < PPB; j++)
        ext[t][j+1] = win1[t][j*PW +: PW];
      ext[t][0] = left_edge ? (cfg_mode ? win1[t][PW-1:0] : '0)
                            : win2[t][BW-1 -: PW];
      ext[t][PPB+1] = bstep ? (cfg_mode ? win1[t][BW-1 -: PW] : '0)
                            : nw[t][PW-1:0];
    end
    result = '0;
    sum    = '0;
    sh     = '0;
    for (int j = 0; j < PPB; j++) begin
      sum = '0;
      for (int t = 0; t < 3; t++)
        for (int k = 0; k < 3; k++)
          sum = sum + AW'(cfg_coef[(3*t+k)*CW +: CW]) * AW'(ext[t][j+k]);
      sh = sum >> cfg_shift;
      result[j*PW +: PW] = (sh > PMAX) ? '1 : sh[PW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      lb[wsel][ccol] <= in_frame;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      ccol      <= '0;
      crow      <= '0;
      wsel      <= 1'b0;
      bubble    <= 1'b0;
      bub_out   <= 1'b0;
      last_bub  <= 1'b0;
      done_wait <= 1'b0;
      live      <= 1'b0;
      cfg_coef  <= '0;
      cfg_shift <= '0;
      cfg_mode  <= 1'b0;
      out_valid <= 1'b0;
      out_frame <= '0;
      for (int t = 0; t < 3; t++) begin
        win1[t] <= '0;
        win2[t] <= '0;
      end
    end else begin
      live <= 1'b1;
      if (emit) begin
        out_valid <= 1'b1;
        out_frame <= result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (step) begin
        for (int t = 0; t < 3; t++) begin
          win2[t] <= win1[t];
          win1[t] <= nw[t];
        end
      end
      if (acc) begin
        if (state == IDLE) begin
          cfg_coef  <= coef;
          cfg_shift <= shift;
          cfg_mode  <= border_mode;
        end
        if (last_col) begin
          ccol    <= '0;
          crow    <= crow + RW'(1);
          wsel    <= ~wsel;
          bubble  <= 1'b1;
          bub_out <= (state == RUN);
          if (state == RUN && crow == LAST_ROW)
            state <= FLUSH;
          else if (state != RUN)
            state <= RUN;
        end else begin
          ccol <= ccol + CCW'(1);
          if (state == IDLE)
            state <= FILL;
        end
      end
      if (fstep) begin
        if (last_col) begin
          ccol     <= '0;
          bubble   <= 1'b1;
          bub_out  <= 1'b1;
          last_bub <= 1'b1;
        end else begin
          ccol <= ccol + CCW'(1);
        end
      end
      if (bstep) begin
        bubble <= 1'b0;
        if (last_bub) begin
          last_bub  <= 1'b0;
          done_wait <= 1'b1;
        end
      end
      if (frame_done) begin
        done_wait <= 1'b0;
        state     <= IDLE;
        crow      <= '0;
      end
    end
  end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised 3x3 convolution filter for the streaming image pipeline; successor to the fixed Gaussian smoother. Accepts PIXELS_PER_BEAT packed pixels per beat under a valid/ready handshake. Applies nine runtime-programmable unsigned coefficients with a programmable right-shift normalisation and saturation. Emits a full, centred, frame-sized output with selectable zero or replicate border handling. Sits between the frame DMA reader and the fusion/weighting stages.

## Interface
- PIXELS_PER_BEAT, 16, pixels per beat; ≥2, divides IMAGE_WIDTH
- IMAGE_WIDTH, 512, pixels per row
- IMAGE_HEIGHT, 512, rows per frame; ≥2
- PIXEL_WIDTH, 8, bits per pixel, unsigned
- COEF_WIDTH, 4, bits per coefficient, unsigned
- clk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- coef  in  9*COEF_WIDTH  coefficients, k = 3*row + col, row 0 = top, col 0 = left; k at [k*COEF_WIDTH +: COEF_WIDTH]
- shift  in  5  normalisation right-shift
- border_mode  in  1  0 = zero padding, 1 = replicate edge pixel
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_frame  in  PIXELS_PER_BEAT*PIXEL_WIDTH  pixel j at [j*PIXEL_WIDTH +: PIXEL_WIDTH]; pixel 0 = leftmost
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid & out_ready
- out_frame  out  PIXELS_PER_BEAT*PIXEL_WIDTH  same packing as in_frame
- frame_done  out  1  one-cycle pulse with the last output beat's handshake

## Operation
- COLS = IMAGE_WIDTH/PIXELS_PER_BEAT beats per row. Input is raster order, no sideband; position is tracked by col/row counters.
- Two line buffers of COLS beats each, used as a circular pair, hold rows r-1 and r. Three-beat horizontal window registers per row supply neighbour pixels across beat boundaries.
- FSM states:
  - IDLE: waits for beat (0,0); samples coef, shift and border_mode on acceptance; → FILL.
  - FILL: accepts row 0; no output; → RUN after beat (0,COLS-1).
  - RUN: accepting input row r+1 produces output row r-... i.e. row r; → FLUSH after beat (H-1,COLS-1).
  - FLUSH: produces output row H-1 with no input; in_ready=0; → IDLE after last output handshake.
- Output pixel (y,x) = sat(Σ coef_k·P(y+dy, x+dx) >> shift).
- Out-of-frame P:
  - border_mode 0: 0.
  - border_mode 1: coordinates clamped to [0,H-1] × [0,W-1].
- Arithmetic:
  - Accumulator width PIXEL_WIDTH+COEF_WIDTH+4; no intermediate overflow.
  - Logical shift.
  - Saturate to 2^PIXEL_WIDTH−1.
- Row-end bubble: after each row's last input beat, one cycle with in_ready=0 emits that row's last output beat (right border).
- Config inputs are ignored mid-frame; a change takes effect at the next frame.
- Default coef {1,2,1,2,4,2,1,2,1} with shift=4 gives the legacy Gaussian.

## Timing
- Reset values: in_ready=0, out_valid=0, out_frame=0, frame_done=0; FSM=IDLE; counters 0. in_ready rises the first cycle after areset deasserts.
- Reset is asynchronous. Assertion mid-frame abandons the frame; line-buffer contents are don't-care because FILL rewrites them.
- Output is a registered skid of depth 1. in_ready = (state≠FLUSH) & ~bubble & (~out_valid | out_ready).
- out_valid and out_frame are held stable until out_ready.
- Latency:
  - Output (r,c), c<COLS-1: out_valid the cycle after input (r+1,c+1) is accepted.
  - Output (r,COLS-1): out_valid the cycle after the bubble following input (r+1,COLS-1).
  - Row H-1: FLUSH emits one beat per cycle when out_ready=1.
- Throughput: COLS·H outputs per (COLS+1)·H + COLS + 1 cycles at full flow.
- Back-to-back frames: a new frame's beat (0,0) may be accepted the cycle after frame_done.

## Test plan
- Default coef, shift=4, mode 0, W=64, H=4, PPB=16, all pixels 160 → interior 160; edge non-corner 120; corners 90; frame_done once.
- Mode 1, same input → every output pixel 160.
- coef all 15, shift=0, pixels 255 → all outputs 255 (saturation); shift=31 → all 0.
- Identity coef {0,0,0,0,1,0,0,0,0}, shift 0, ramp pixel = x+y → output equals input beat-for-beat, including beat-boundary pixels 15/16.
- Random in_valid and out_ready toggling → output identical to the unstalled run; out_frame never changes while out_valid & ~out_ready.
- areset asserted mid-RUN, then a clean frame → outputs all 0 immediately; second frame bit-exact to the golden model.
